mem_arbiter: RTL

- Two-requester arbiter for the core's single-port word memory.
- Shares the memory between the multicycle core (fetch and load/store port) and an external master (boot loader or debug DMA).
- Sits between the core's memory address/data mux and the memory block; fixes the read data timing the core's controller relies on.
- Round-robin arbitration, plus a bounded burst lock for the external master.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state, requester id,
// and the round-robin pick used while arbitrating.
package mem_arb_pkg;

  typedef enum logic {ARB = 1'b0, LOCK_EXT = 1'b1} arb_state_t;
  typedef enum logic {REQ_CORE = 1'b0, REQ_EXT = 1'b1} req_id_t;

  // A lone requester wins; on a contest the one not served last wins.
  function automatic req_id_t rr_pick(input logic core_req, input logic ext_req,
                                      input req_id_t last);
    req_id_t w_pick;
    if (core_req && ext_req) begin
      w_pick = (last == REQ_CORE) ? REQ_EXT : REQ_CORE;
    end else if (ext_req) begin
      w_pick = REQ_EXT;
    end else begin
      w_pick = REQ_CORE;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core / external master, the arbiter and the memory.
// master = requesters and memory (environment side), slave = arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_lock;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_wen;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_wen, mem_ren, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_wen, mem_ren, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the single-port word memory with a bounded burst lock
// for the external master. Grants are same-cycle; read data returns one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input logic        clk,
  input logic        rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

  arb_state_t        r_st;
  arb_state_t        w_st_nxt;
  req_id_t           r_last;
  req_id_t           w_last_nxt;
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [CNT_W-1:0]  w_lock_cnt_nxt;
  logic              r_rv_core;
  logic              r_rv_ext;
  logic              w_core_gnt;
  logic              w_ext_gnt;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // State register: FSM, round-robin pointer, lock counter and read-return flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st       <= ARB;
      r_last     <= REQ_EXT;
      r_lock_cnt <= CNT_ZERO;
      r_rv_core  <= 1'b0;
      r_rv_ext   <= 1'b0;
    end else begin
      r_st       <= w_st_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rv_core  <= w_core_gnt & ~bus.core_we;
      r_rv_ext   <= w_ext_gnt & ~bus.ext_we;
    end
  end

  // Next-state: lock entry/exit and round-robin pointer update.
  always_comb begin
    w_st_nxt       = r_st;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_st)
      ARB: begin
        if (w_core_gnt) begin
          w_last_nxt = REQ_CORE;
        end else if (w_ext_gnt) begin
          w_last_nxt = REQ_EXT;
          if (bus.ext_lock) begin
            w_st_nxt       = LOCK_EXT;
            w_lock_cnt_nxt = CNT_ONE;
          end else begin
            w_lock_cnt_nxt = CNT_ZERO;
          end
        end else begin
          w_lock_cnt_nxt = CNT_ZERO;
        end
      end
      LOCK_EXT: begin
        // Leaving the lock always hands the next contest to the core.
        if (w_ext_gnt) begin
          if (!bus.ext_lock || (r_lock_cnt == CNT_LAST)) begin
            w_st_nxt       = ARB;
            w_last_nxt     = REQ_EXT;
            w_lock_cnt_nxt = CNT_ZERO;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
          end
        end else if (!bus.ext_lock) begin
          w_st_nxt       = ARB;
          w_last_nxt     = REQ_EXT;
          w_lock_cnt_nxt = CNT_ZERO;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt;
        end
      end
      default: begin
        w_st_nxt       = ARB;
        w_last_nxt     = REQ_EXT;
        w_lock_cnt_nxt = CNT_ZERO;
      end
    endcase
  end

  // Output decode: same-cycle grants, suppressed during reset.
  always_comb begin
    w_core_gnt = 1'b0;
    w_ext_gnt  = 1'b0;
    if (rst) begin
      w_core_gnt = 1'b0;
      w_ext_gnt  = 1'b0;
    end else begin
      case (r_st)
        ARB: begin
          if (rr_pick(bus.core_req, bus.ext_req, r_last) == REQ_CORE) begin
            w_core_gnt = bus.core_req;
          end else begin
            w_ext_gnt = bus.ext_req;
          end
        end
        LOCK_EXT: w_ext_gnt = bus.ext_req;
        default: begin
          w_core_gnt = 1'b0;
          w_ext_gnt  = 1'b0;
        end
      endcase
    end
  end

  assign w_mem_addr  = w_ext_gnt ? bus.ext_addr  : bus.core_addr;
  assign w_mem_wdata = w_ext_gnt ? bus.ext_wdata : bus.core_wdata;

  assign bus.core_gnt    = w_core_gnt;
  assign bus.ext_gnt     = w_ext_gnt;
  assign bus.mem_wen     = (w_core_gnt & bus.core_we) | (w_ext_gnt & bus.ext_we);
  assign bus.mem_ren     = (w_core_gnt & ~bus.core_we) | (w_ext_gnt & ~bus.ext_we);
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
  assign bus.core_rvalid = r_rv_core & ~rst;
  assign bus.ext_rvalid  = r_rv_ext & ~rst;
  assign bus.core_rdata  = bus.mem_rdata;
  assign bus.ext_rdata   = bus.mem_rdata;

endmodule
